// File: rtl/wall_scroller.sv
// wall_scroller: position generator for the single scrolling wall (pipe).
// The wall moves left by SPEED px on each frame tick. It reappears at the right
// edge with a gap height taken from a free-running LFSR, and freezes when the
// collision checker reports a touch. The `passed` output pulses once per wall,
// on the tick where the wall's right edge crosses to the left of the bird.
module wall_scroller #(
   parameter int SCREEN_W  = 160,
   parameter int WALL_W    = 12,
   parameter int SPEED     = 2,
   parameter int GAP_H     = 40,
   parameter int GAP_MIN_Y = 10,
   parameter int GAP_RANGE = 60,
   parameter int BIRD_X    = 40,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       tick,
   input  logic       touched,
   output logic [7:0] wall_xleft,
   output logic [7:0] wall_xright,
   output logic [7:0] wall_topy,
   output logic [7:0] wall_bottomy,
   output logic       wall_active,
   output logic       passed
);

   // All coordinate arithmetic is 8-bit unsigned.
   localparam logic [7:0] SPAWN_XL  = 8'(SCREEN_W);
   localparam logic [7:0] SPAWN_XR  = 8'(SCREEN_W + WALL_W - 1);
   localparam logic [7:0] SPEED8    = 8'(SPEED);
   localparam logic [7:0] GAP_H8    = 8'(GAP_H);
   localparam logic [7:0] GAP_MIN8  = 8'(GAP_MIN_Y);
   localparam logic [7:0] GAP_RNG8  = 8'(GAP_RANGE);
   localparam logic [7:0] BIRD_X8   = 8'(BIRD_X);
   localparam logic [7:0] RST_TOPY  = 8'(GAP_MIN_Y + GAP_RANGE / 2);
   localparam logic [7:0] RST_BOTY  = 8'(GAP_MIN_Y + GAP_RANGE / 2 + GAP_H);

   typedef enum logic [1:0] {IDLE, RESPAWN, SCROLL, FROZEN} state_t;

   state_t     state_reg, state_next;
   logic [7:0] xleft_reg, xleft_next;
   logic [7:0] xright_reg, xright_next;
   logic [7:0] topy_reg, topy_next;
   logic [7:0] bottomy_reg, bottomy_next;
   logic       passed_reg, passed_next;
   logic       active_reg;
   logic [7:0] lfsr_reg, lfsr_next;
   logic [7:0] gap_r;
   logic [7:0] topy_pick;
   logic [7:0] xleft_moved, xright_moved;

   // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0.
   assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
         assign lfsr_next[gi] = lfsr_reg[gi-1];
      end
   endgenerate

   // Gap pick: fold the 6-bit random value into [0, GAP_RANGE) with one subtract.
   always_comb begin
      gap_r = {2'b00, lfsr_reg[5:0]};
      if (gap_r >= GAP_RNG8) begin
         gap_r = gap_r - GAP_RNG8;
      end
      topy_pick = GAP_MIN8 + gap_r;
   end

   assign xleft_moved  = xleft_reg - SPEED8;
   assign xright_moved = xright_reg - SPEED8;

   // Next-state and next-output logic for the wall FSM.
   always_comb begin
      state_next   = state_reg;
      xleft_next   = xleft_reg;
      xright_next  = xright_reg;
      topy_next    = topy_reg;
      bottomy_next = bottomy_reg;
      passed_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RESPAWN;
            end
         end
         RESPAWN: begin
            xleft_next   = SPAWN_XL;
            xright_next  = SPAWN_XR;
            topy_next    = topy_pick;
            bottomy_next = topy_pick + GAP_H8;
            state_next   = SCROLL;
         end
         SCROLL: begin
            if (touched) begin
               // A touch wins over a simultaneous tick: the wall stays put.
               state_next = FROZEN;
            end else if (tick) begin
               if (xleft_reg < SPEED8) begin
                  // Moving would underflow; the wall leaves the screen instead.
                  state_next = RESPAWN;
               end else begin
                  xleft_next  = xleft_moved;
                  xright_next = xright_moved;
                  // xright only decreases, so this crossing happens once per wall.
                  passed_next = (xright_reg >= BIRD_X8) && (xright_moved < BIRD_X8);
               end
            end
         end
         FROZEN: begin
            if (start) begin
               state_next = RESPAWN;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, coordinate, pulse and LFSR registers with asynchronous reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         xleft_reg   <= SPAWN_XL;
         xright_reg  <= SPAWN_XR;
         topy_reg    <= RST_TOPY;
         bottomy_reg <= RST_BOTY;
         passed_reg  <= 1'b0;
         active_reg  <= 1'b0;
         lfsr_reg    <= LFSR_SEED;
      end else begin
         state_reg   <= state_next;
         xleft_reg   <= xleft_next;
         xright_reg  <= xright_next;
         topy_reg    <= topy_next;
         bottomy_reg <= bottomy_next;
         passed_reg  <= passed_next;
         active_reg  <= (state_next == SCROLL);
         lfsr_reg    <= lfsr_next;
      end
   end

   assign wall_xleft   = xleft_reg;
   assign wall_xright  = xright_reg;
   assign wall_topy    = topy_reg;
   assign wall_bottomy = bottomy_reg;
   assign wall_active  = active_reg;
   assign passed       = passed_reg;

endmodule

// File: tb/tb_wall_scroller.sv
// tb_wall_scroller: directed test of the wall scroller with default parameters.
module tb_wall_scroller;

   logic       clk;
   logic       resetn;
   logic       start;
   logic       tick;
   logic       touched;
   logic [7:0] wall_xleft;
   logic [7:0] wall_xright;
   logic [7:0] wall_topy;
   logic [7:0] wall_bottomy;
   logic       wall_active;
   logic       passed;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] lfsr_model;
   logic [7:0] l_resp;
   logic [7:0] t_exp;

   wall_scroller dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .tick         (tick),
      .touched      (touched),
      .wall_xleft   (wall_xleft),
      .wall_xright  (wall_xright),
      .wall_topy    (wall_topy),
      .wall_bottomy (wall_bottomy),
      .wall_active  (wall_active),
      .passed       (passed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, shifted in at bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   // Expected topy for a given LFSR value: 10 + (low 6 bits mod 60).
   function automatic logic [7:0] exp_topy(input logic [7:0] l);
      int v;
      v = 10 + (int'(l[5:0]) % 60);
      return 8'(v);
   endfunction

   // The LFSR runs every cycle regardless of state, so it is tracked here too.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_model <= 8'hA5;
      else         lfsr_model <= lfsr_step(lfsr_model);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_coords(input string tag, input int xl, input int xr,
                               input int ty, input int by);
      check({tag, ".xleft"},   16'(wall_xleft),   16'(xl));
      check({tag, ".xright"},  16'(wall_xright),  16'(xr));
      check({tag, ".topy"},    16'(wall_topy),    16'(ty));
      check({tag, ".bottomy"}, 16'(wall_bottomy), 16'(by));
   endtask

   // One-cycle tick; returns #1 after the edge that consumed it.
   task automatic do_tick();
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   initial begin
      resetn  = 1'b0;
      start   = 1'b0;
      tick    = 1'b0;
      touched = 1'b0;

      // Reset values while held in reset.
      repeat (2) @(posedge clk);
      #1;
      check_coords("reset", 160, 171, 40, 80);
      check("reset.active", 16'(wall_active), 16'd0);
      check("reset.passed", 16'(passed), 16'd0);
      #2 resetn = 1'b1;

      // IDLE ignores ticks.
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      check("idle.active", 16'(wall_active), 16'd0);
      check_coords("idle", 160, 171, 40, 80);

      // 1) start -> RESPAWN -> SCROLL with an LFSR-picked gap.
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      l_resp = lfsr_model;
      check("respawn1.active", 16'(wall_active), 16'd0);
      @(posedge clk);
      #1;
      t_exp = exp_topy(l_resp);
      check("scroll1.active", 16'(wall_active), 16'd1);
      check_coords("scroll1", 160, 171, int'(t_exp), int'(t_exp) + 40);

      // 2) Five ticks move the wall 10 px; no pass yet.
      for (int i = 0; i < 5; i++) begin
         do_tick();
         check("move5.passed", 16'(passed), 16'd0);
      end
      check_coords("move5", 150, 161, int'(t_exp), int'(t_exp) + 40);

      // 3) Walk to xright=41, then cross the bird column.
      for (int i = 0; i < 60; i++) do_tick();
      check_coords("pre_pass", 30, 41, int'(t_exp), int'(t_exp) + 40);
      check("pre_pass.passed", 16'(passed), 16'd0);
      do_tick();
      check("cross.xright", 16'(wall_xright), 16'd39);
      check("cross.passed", 16'(passed), 16'd1);
      @(posedge clk);
      #1 check("cross_next.passed", 16'(passed), 16'd0);
      for (int i = 0; i < 14; i++) begin
         do_tick();
         check("after_pass.passed", 16'(passed), 16'd0);
      end
      check_coords("left_edge", 0, 11, int'(t_exp), int'(t_exp) + 40);
      check("left_edge.active", 16'(wall_active), 16'd1);

      // 4) xleft below SPEED: tick respawns instead of wrapping.
      do_tick();
      l_resp = lfsr_model;
      check("wrap.active", 16'(wall_active), 16'd0);
      check("wrap.xleft", 16'(wall_xleft), 16'd0);
      check("wrap.passed", 16'(passed), 16'd0);
      @(posedge clk);
      #1;
      t_exp = exp_topy(l_resp);
      check("respawn2.active", 16'(wall_active), 16'd1);
      check_coords("respawn2", 160, 171, int'(t_exp), int'(t_exp) + 40);

      // 5) touched and tick together: freeze with no move.
      tick    = 1'b1;
      touched = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      touched = 1'b0;
      check("frozen.active", 16'(wall_active), 16'd0);
      check_coords("frozen", 160, 171, int'(t_exp), int'(t_exp) + 40);
      touched = 1'b1;
      for (int i = 0; i < 3; i++) do_tick();
      touched = 1'b0;
      check("frozen_ticks.xleft", 16'(wall_xleft), 16'd160);
      check("frozen_ticks.active", 16'(wall_active), 16'd0);
      check("frozen_ticks.passed", 16'(passed), 16'd0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      l_resp = lfsr_model;
      check("restart.resp_active", 16'(wall_active), 16'd0);
      @(posedge clk);
      #1;
      t_exp = exp_topy(l_resp);
      check("restart.active", 16'(wall_active), 16'd1);
      check_coords("restart", 160, 171, int'(t_exp), int'(t_exp) + 40);

      // 6) Asynchronous reset between clock edges mid-SCROLL.
      for (int i = 0; i < 3; i++) do_tick();
      check("pre_rst.xleft", 16'(wall_xleft), 16'd154);
      #2 resetn = 1'b0;
      #1;
      check_coords("async_rst", 160, 171, 40, 80);
      check("async_rst.active", 16'(wall_active), 16'd0);
      check("async_rst.passed", 16'(passed), 16'd0);
      #2 resetn = 1'b1;
      @(posedge clk);
      #1 check("post_rst.active", 16'(wall_active), 16'd0);

      // LFSR restarts from its seed after reset.
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      l_resp = lfsr_model;
      @(posedge clk);
      #1;
      t_exp = exp_topy(l_resp);
      check("reseed.active", 16'(wall_active), 16'd1);
      check_coords("reseed", 160, 171, int'(t_exp), int'(t_exp) + 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
